// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer: loads a frame into a kernel array, waits CONV_LAT cycles, streams zero-bordered results.
// Optional macro HARRIS_FLAG_EN adds the kern_flag -> out_flag corner-flag path.
module conv_frame_sequencer #(
   parameter int IMG_W    = 8,
   parameter int IMG_H    = 8,
   parameter int PIX_W    = 8,
   parameter int PAD      = 1,
   parameter int CONV_LAT = 4,
   parameter int ADDR_W   = $clog2(IMG_W*IMG_H)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PIX_W-1:0]  in_data,
   output logic              kern_we,
   output logic [ADDR_W-1:0] kern_addr,
   output logic [PIX_W-1:0]  kern_wdata,
   input  logic [PIX_W-1:0]  kern_rdata,
`ifdef HARRIS_FLAG_EN
   input  logic              kern_flag,
   output logic              out_flag,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PIX_W-1:0]  out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   output logic              busy
);
   localparam int LW = $clog2(CONV_LAT+1);
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(IMG_W*IMG_H-1);
   localparam logic [ADDR_W-1:0] P_LO  = ADDR_W'(PAD);
   localparam logic [ADDR_W-1:0] X_HI  = ADDR_W'(IMG_W-PAD);
   localparam logic [ADDR_W-1:0] Y_HI  = ADDR_W'(IMG_H-PAD);
   localparam logic [ADDR_W-1:0] X_MAX = ADDR_W'(IMG_W-1);
   localparam logic [LW-1:0] LAT_MAX = LW'(CONV_LAT-1);

   typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, STREAM} state_t;
   state_t state;
   logic [ADDR_W-1:0] wr_cnt, rd_cnt, rd_nxt, col, row;
   logic [LW-1:0] lat_cnt;
   logic fin, accept, adv, last_hs, border;

   assign accept     = in_valid & in_ready;
   assign kern_we    = accept;
   assign kern_wdata = in_data;
   assign adv        = state == STREAM && (!out_valid || out_ready) && !fin;
   assign last_hs    = out_valid & out_ready & out_last;
   assign border     = col < P_LO || col >= X_HI || row < P_LO || row >= Y_HI;
   // Address the pixel that will be captured next cycle, so a stalled capture simply re-reads it
   assign rd_nxt     = adv && rd_cnt != LAST ? rd_cnt + 1'b1 : rd_cnt;
   assign kern_addr  = state == STREAM || state == COMPUTE ? rd_nxt : wr_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         col       <= '0;
         row       <= '0;
         lat_cnt   <= '0;
         fin       <= 1'b0;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         out_addr  <= '0;
`ifdef HARRIS_FLAG_EN
         out_flag  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, LOAD: begin
               in_ready <= !(accept && wr_cnt == LAST);
               if (accept) begin
                  busy   <= 1'b1;
                  wr_cnt <= wr_cnt == LAST ? '0 : wr_cnt + 1'b1;
                  state  <= wr_cnt == LAST ? COMPUTE : LOAD;
               end
            end
            COMPUTE: begin
               lat_cnt <= lat_cnt == LAT_MAX ? '0 : lat_cnt + 1'b1;
               if (lat_cnt == LAT_MAX) state <= STREAM;
            end
            default: begin
               if (adv) begin
                  out_valid <= 1'b1;
                  out_data  <= border ? '0 : kern_rdata;
                  out_addr  <= rd_cnt;
                  out_last  <= rd_cnt == LAST;
`ifdef HARRIS_FLAG_EN
                  out_flag  <= !border & kern_flag;
`endif
                  fin       <= rd_cnt == LAST;
                  rd_cnt    <= rd_nxt;
                  col       <= col == X_MAX ? '0 : col + 1'b1;
                  row       <= col == X_MAX ? row + 1'b1 : row;
               end else if (last_hs) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  fin       <= 1'b0;
                  rd_cnt    <= '0;
                  col       <= '0;
                  row       <= '0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb_conv_frame_sequencer: directed vectors for the 8x8 and 6x4 frame sequencer configurations.
// Define HARRIS_FLAG_EN to also exercise the corner-flag path.
module tb_conv_frame_sequencer;
   localparam int N  = 64;
   localparam int N6 = 24;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       in_valid = 1'b0, out_ready = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_ready, kern_we, out_valid, out_last, busy;
   logic [7:0] kern_wdata, kern_rdata, out_data;
   logic [5:0] kern_addr, out_addr;
`ifdef HARRIS_FLAG_EN
   logic kern_flag, out_flag, kf6, of6;
`endif

   logic       v6 = 1'b0;
   logic [7:0] d6 = '0;
   logic       rdy6, we6, ov6, ol6, b6;
   logic [7:0] wd6, rd6, od6;
   logic [4:0] a6, oa6;

   conv_frame_sequencer dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .kern_we(kern_we), .kern_addr(kern_addr), .kern_wdata(kern_wdata), .kern_rdata(kern_rdata),
`ifdef HARRIS_FLAG_EN
      .kern_flag(kern_flag), .out_flag(out_flag),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
      .out_last(out_last), .busy(busy)
   );

   conv_frame_sequencer #(.IMG_W(6), .IMG_H(4)) u6 (
      .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(rdy6), .in_data(d6),
      .kern_we(we6), .kern_addr(a6), .kern_wdata(wd6), .kern_rdata(rd6),
`ifdef HARRIS_FLAG_EN
      .kern_flag(kf6), .out_flag(of6),
`endif
      .out_valid(ov6), .out_ready(1'b1), .out_data(od6), .out_addr(oa6),
      .out_last(ol6), .busy(b6)
   );

   // Kernel array models: 1-cycle synchronous read
   logic [7:0] mem [0:63];
   logic [7:0] mem6 [0:31];
   always @(posedge clk) begin
      if (kern_we) mem[kern_addr] <= kern_wdata;
      kern_rdata <= mem[kern_addr];
      if (we6) mem6[a6] <= wd6;
      rd6 <= mem6[a6];
`ifdef HARRIS_FLAG_EN
      kern_flag <= kern_addr == 6'd18 || kern_addr == 6'd0;
      kf6 <= 1'b0;
`endif
   end

   int vec = 0, bad = 0;
   task automatic chk(string name, int got, int exp);
      vec++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic int model_pix(int i);
      int x = i % 8, y = i / 8;
      return (x < 1 || x > 6 || y < 1 || y > 6) ? 0 : i + 1;
   endfunction

   int mode = 0;
   logic [7:0] got_data [N];
   logic [5:0] got_addr [N];
   logic       got_last [N];
   logic       got_flag [N];
   logic [7:0] ref_data [N];
   int n_out = 0, we_cnt = 0;
   bit last_seen = 0, chk_first = 0;
   logic pv = 0, pr = 0, pl = 0;
   logic [7:0] pd = '0;
   logic [5:0] pa = '0;

   always @(negedge clk) begin
      if (pv && !pr) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_data", out_data, pd);
         chk("hold_addr", out_addr, pa);
         chk("hold_last", out_last, pl);
      end
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? ($urandom_range(9) >= 3) : 1'b0;
      if (out_valid && out_ready && n_out < N) begin
         got_data[n_out] = out_data;
         got_addr[n_out] = out_addr;
         got_last[n_out] = out_last;
`ifdef HARRIS_FLAG_EN
         got_flag[n_out] = out_flag;
`else
         got_flag[n_out] = 1'b0;
`endif
         n_out++;
         if (out_last) last_seen = 1;
      end
      pv = out_valid; pr = out_ready; pd = out_data; pa = out_addr; pl = out_last;
      if (kern_we) begin
         we_cnt++;
         if (chk_first) begin
            chk("first_we_addr", kern_addr, 0);
            chk_first = 0;
         end
      end
   end

   logic [7:0] g6_d [N6];
   logic [4:0] g6_a [N6];
   logic       g6_l [N6];
   int n6 = 0, we6_cnt = 0;
   always @(negedge clk) begin
      if (we6) we6_cnt++;
      if (ov6 && n6 < N6) begin
         g6_d[n6] = od6; g6_a[n6] = oa6; g6_l[n6] = ol6;
         n6++;
      end
   end

   task automatic load_frame(int n, bit gaps, int abort_at);
      int p = 0, t = 0;
      while (p < n && t < 4000) begin
         @(posedge clk); #1;
         if (p == abort_at) begin
            in_valid = 1'b0;
            rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            return;
         end
         t++;
         in_valid = !gaps || $urandom_range(1) == 1;
         in_data = 8'(p + 1);
         if (in_valid && in_ready) p++;
      end
      chk("load_beats", p, n);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_frame();
      int t = 0;
      while (!last_seen && t < 5000) begin
         @(posedge clk);
         t++;
      end
      chk("frame_done", last_seen, 1);
   endtask

   task automatic compare_ref(string name);
      chk({name, "_count"}, n_out, N);
      for (int i = 0; i < N; i++) begin
         chk({name, "_addr"}, got_addr[i], i);
         chk({name, "_data"}, got_data[i], ref_data[i]);
      end
   endtask

   typedef struct { int idx; int data; bit last; } vec_t;
   vec_t tbl [12];
   int in6 [8];

   initial begin
      int lat;
      bit inner;
      tbl = '{'{0,0,0}, '{7,0,0}, '{8,0,0}, '{9,10,0}, '{15,0,0}, '{18,19,0},
              '{36,37,0}, '{54,55,0}, '{55,0,0}, '{56,0,0}, '{62,0,0}, '{63,0,1}};
      in6 = '{7, 8, 9, 10, 13, 14, 15, 16};

      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_kern_we", kern_we, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_addr", out_addr, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Clean 8x8 frame
      chk_first = 1; we_cnt = 0; n_out = 0; last_seen = 0; mode = 0;
      load_frame(N, 0, -1);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            chk("compute_in_ready", in_ready, 0);
            chk("compute_busy", busy, 1);
         end
      end while (!out_valid && lat < 50);
      chk("first_valid_lat", lat, 6);
      wait_frame();
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_in_ready", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);
      chk("clean_we_cnt", we_cnt, N);
      chk("clean_count", n_out, N);
      for (int i = 0; i < N; i++) begin
         chk("clean_addr", got_addr[i], i);
         chk("clean_data", got_data[i], model_pix(i));
         chk("clean_last", got_last[i], i == N - 1);
         ref_data[i] = got_data[i];
`ifdef HARRIS_FLAG_EN
         chk("flag", got_flag[i], i == 18);
`endif
      end
      for (int i = 0; i < 12; i++) begin
         chk("tbl_data", got_data[tbl[i].idx], tbl[i].data);
         chk("tbl_last", got_last[tbl[i].idx], tbl[i].last);
      end

      // Back-to-back frame with input gaps and output backpressure
      chk_first = 1; n_out = 0; last_seen = 0; mode = 1;
      load_frame(N, 1, -1);
      wait_frame();
      mode = 0;
      compare_ref("stall");

      // Reset mid-load, then a full frame
      chk_first = 1;
      load_frame(N, 0, 20);
      chk("abort_busy", busy, 0);
      chk("abort_out_valid", out_valid, 0);
      chk_first = 1; we_cnt = 0; n_out = 0; last_seen = 0;
      load_frame(N, 0, -1);
      wait_frame();
      chk("abort_we_cnt", we_cnt, N);
      compare_ref("abort");

      // Long stall with out_ready low, then release
      n_out = 0; last_seen = 0; mode = 2;
      load_frame(N, 0, -1);
      repeat (150) @(negedge clk);
      chk("park_valid", out_valid, 1);
      chk("park_addr", out_addr, 0);
      chk("park_busy", busy, 1);
      chk("park_in_ready", in_ready, 0);
      chk("park_count", n_out, 0);
      mode = 0;
      wait_frame();
      compare_ref("park");

      // Non-square 6x4 frame
      we6_cnt = 0; n6 = 0;
      for (int p = 0; p < N6; p++) begin
         @(posedge clk); #1;
         v6 = 1'b1;
         d6 = 8'(p + 1);
      end
      @(posedge clk); #1 v6 = 1'b0;
      for (int t = 0; t < 200 && n6 < N6; t++) @(posedge clk);
      chk("six_we_cnt", we6_cnt, N6);
      chk("six_count", n6, N6);
      for (int i = 0; i < N6; i++) begin
         inner = 0;
         for (int k = 0; k < 8; k++) if (in6[k] == i) inner = 1;
         chk("six_addr", g6_a[i], i);
         chk("six_data", g6_d[i], inner ? i + 1 : 0);
         chk("six_last", g6_l[i], i == N6 - 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule
